wb_periph_mux: RTL and testbench

WB_PERIPH_MUX -- requirements
Module: wb_periph_mux

---
 rtl/wb_periph_pkg.sv | 23 ++
 rtl/wb_addr_dec.sv | 32 +++
 rtl/wb_periph_mux.sv | 242 ++++++++++++++++++++++++
 tb/tb_wb_periph_mux.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_periph_pkg.sv
// Shared types for the Wishbone peripheral multiplexer: FSM state encoding and
// the slave-index width helper.
package wb_periph_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    WAIT   = 3'd2,
    DECERR = 3'd3,
    RESP   = 3'd4
  } state_e;

  // Never returns less than 1 so a single-slave build still has a legal index.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/wb_addr_dec.sv
// Combinational base/mask address decoder; the lowest matching slave index wins
// when windows overlap.
module wb_addr_dec
  import wb_periph_pkg::*;
#(
  parameter int                NS         = 6,
  parameter int                AW         = 32,
  parameter logic [NS*AW-1:0]  SLAVE_ADDR = '0,
  parameter logic [NS*AW-1:0]  SLAVE_MASK = '1
) (
  input  logic [AW-1:0]        adr_i,
  output logic                 hit_o,
  output logic [clog2(NS)-1:0] idx_o
);

  localparam int IW = clog2(NS);

  logic match_s;

  // Scan from the top index down so the lowest matching index is written last.
  always_comb begin
    hit_o   = 1'b0;
    idx_o   = '0;
    match_s = 1'b0;
    for (int i = NS - 1; i >= 0; i--) begin
      match_s = ((adr_i & SLAVE_MASK[i*AW +: AW]) == SLAVE_ADDR[i*AW +: AW]);
      hit_o   = hit_o | match_s;
      idx_o   = match_s ? IW'(i) : idx_o;
    end
  end

endmodule

// File: rtl/wb_periph_mux.sv
// Single-master to NS-slave pipelined Wishbone multiplexer with decode-error
// response. Define WB_PERIPH_MUX_TIMEOUT_EN to add the REQ/WAIT watchdog.
module wb_periph_mux
  import wb_periph_pkg::*;
#(
  parameter int               NS             = 6,
  parameter int               AW             = 32,
  parameter int               DW             = 32,
  parameter logic [NS*AW-1:0] SLAVE_ADDR     = '0,
  parameter logic [NS*AW-1:0] SLAVE_MASK     = '1,
  parameter int               TIMEOUT_CYCLES = 255
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 wbm_cyc_i,
  input  logic                 wbm_stb_i,
  input  logic                 wbm_we_i,
  input  logic [AW-1:0]        wbm_adr_i,
  input  logic [DW-1:0]        wbm_dat_i,
  input  logic [DW/8-1:0]      wbm_sel_i,
  output logic                 wbm_ack_o,
  output logic                 wbm_err_o,
  output logic                 wbm_stall_o,
  output logic [DW-1:0]        wbm_dat_o,
  output logic [NS-1:0]        s_cyc_o,
  output logic [NS-1:0]        s_stb_o,
  output logic [NS-1:0]        s_we_o,
  output logic [NS*AW-1:0]     s_adr_o,
  output logic [NS*DW-1:0]     s_dat_o,
  output logic [NS*DW/8-1:0]   s_sel_o,
  input  logic [NS-1:0]        s_ack_i,
  input  logic [NS-1:0]        s_err_i,
  input  logic [NS-1:0]        s_stall_i,
  input  logic [NS*DW-1:0]     s_dat_i,
  output logic                 busy_o
);

  localparam int IW = clog2(NS);
  localparam int SW = DW / 8;

  if (NS < 1 || NS > 16 || (DW % 8) != 0 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
    $error("wb_periph_mux: parameter out of range");
  end

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [AW-1:0]   adr_q, adr_d;
  logic [DW-1:0]   dat_q, dat_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic            we_q, we_d;
  logic [NS-1:0]   cyc_q, cyc_d;
  logic [NS-1:0]   stb_q, stb_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;
  logic            stall_q, stall_d;
  logic            busy_q, busy_d;
  logic [DW-1:0]   rdat_q, rdat_d;

  logic            dec_hit_s;
  logic [IW-1:0]   dec_idx_s;
  logic            req_s;
  logic            tmo_s;
  logic            sl_ack_s, sl_err_s, sl_stall_s;
  logic [DW-1:0]   sl_dat_s;

  wb_addr_dec #(
    .NS         (NS),
    .AW         (AW),
    .SLAVE_ADDR (SLAVE_ADDR),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_dec (
    .adr_i (wbm_adr_i),
    .hit_o (dec_hit_s),
    .idx_o (dec_idx_s)
  );

  assign req_s      = wbm_cyc_i & wbm_stb_i;
  assign sl_ack_s   = s_ack_i[idx_q];
  assign sl_err_s   = s_err_i[idx_q];
  assign sl_stall_s = s_stall_i[idx_q];
  assign sl_dat_s   = s_dat_i[idx_q*DW +: DW];

`ifdef WB_PERIPH_MUX_TIMEOUT_EN
  logic [15:0] wdog_q, wdog_d;

  assign tmo_s = (wdog_q == 16'(TIMEOUT_CYCLES - 1));

  // Watchdog: restarts on acceptance, advances on every REQ/WAIT cycle.
  always_comb begin
    if (state_q == IDLE) begin
      wdog_d = req_s ? 16'd0 : wdog_q;
    end else if (state_q == REQ || state_q == WAIT) begin
      wdog_d = wdog_q + 16'd1;
    end else begin
      wdog_d = wdog_q;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wdog_q <= 16'd0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`else
  assign tmo_s = 1'b0;
`endif

  // Next-state logic; master abort beats a slave response, which beats timeout.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    cyc_d   = cyc_q;
    stb_d   = stb_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rdat_d  = rdat_q;
    case (state_q)
      IDLE: begin
        if (req_s) begin
          adr_d = wbm_adr_i;
          dat_d = wbm_dat_i;
          sel_d = wbm_sel_i;
          we_d  = wbm_we_i;
          idx_d = dec_idx_s;
          if (dec_hit_s) begin
            state_d = REQ;
            cyc_d   = NS'(1) << dec_idx_s;
            stb_d   = NS'(1) << dec_idx_s;
          end else begin
            state_d = DECERR;
          end
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (!wbm_cyc_i) begin
          state_d = IDLE;
          cyc_d   = '0;
          stb_d   = '0;
        end else if (tmo_s) begin
          state_d = RESP;
          cyc_d   = '0;
          stb_d   = '0;
          err_d   = 1'b1;
          rdat_d  = '0;
        end else if (!sl_stall_s) begin
          state_d = WAIT;
          stb_d   = '0;
        end else begin
          state_d = REQ;
        end
      end
      WAIT: begin
        if (!wbm_cyc_i) begin
          state_d = IDLE;
          cyc_d   = '0;
        end else if (sl_ack_s || sl_err_s) begin
          state_d = RESP;
          cyc_d   = '0;
          ack_d   = ~sl_err_s;
          err_d   = sl_err_s;
          rdat_d  = sl_dat_s;
        end else if (tmo_s) begin
          state_d = RESP;
          cyc_d   = '0;
          err_d   = 1'b1;
          rdat_d  = '0;
        end else begin
          state_d = WAIT;
        end
      end
      DECERR: begin
        state_d = RESP;
        err_d   = 1'b1;
        rdat_d  = '0;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cyc_d   = '0;
        stb_d   = '0;
      end
    endcase
    stall_d = (state_d != IDLE);
    busy_d  = (state_d != IDLE);
  end

  // FSM and all registered outputs.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      cyc_q   <= '0;
      stb_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      stall_q <= 1'b0;
      busy_q  <= 1'b0;
      rdat_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      stall_q <= stall_d;
      busy_q  <= busy_d;
      rdat_q  <= rdat_d;
    end
  end

  assign wbm_ack_o   = ack_q;
  assign wbm_err_o   = err_q;
  assign wbm_stall_o = stall_q;
  assign wbm_dat_o   = rdat_q;
  assign busy_o      = busy_q;
  assign s_cyc_o     = cyc_q;
  assign s_stb_o     = stb_q;
  assign s_we_o      = {NS{we_q}};
  assign s_adr_o     = {NS{adr_q}};
  assign s_dat_o     = {NS{dat_q}};
  assign s_sel_o     = {NS{sel_q}};

endmodule

// File: tb/tb_wb_periph_mux.sv
// Self-checking bench for wb_periph_mux: directed scenarios plus randomized
// transactions scored against a cycle-count reference model.
module tb_wb_periph_mux;

  localparam int NS  = 6;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 8;

  localparam logic [31:0] BASES [NS] = '{32'h0300_0000, 32'h0100_0000, 32'h0200_0000,
                                         32'h0300_0000, 32'h0400_0000, 32'h0500_0000};
  localparam logic [31:0] MASKS [NS] = '{32'hFFFF_0000, 32'hFF00_0000, 32'hFF00_0000,
                                         32'hFF00_0000, 32'hFF00_0000, 32'hFF00_0000};
  localparam logic [NS*AW-1:0] P_ADDR = {BASES[5], BASES[4], BASES[3], BASES[2], BASES[1], BASES[0]};
  localparam logic [NS*AW-1:0] P_MASK = {MASKS[5], MASKS[4], MASKS[3], MASKS[2], MASKS[1], MASKS[0]};

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              m_cyc = 1'b0, m_stb = 1'b0, m_we = 1'b0;
  logic [AW-1:0]     m_adr = '0;
  logic [DW-1:0]     m_wdat = '0;
  logic [DW/8-1:0]   m_sel = '0;
  logic              wbm_ack_o, wbm_err_o, wbm_stall_o, busy_o;
  logic [DW-1:0]     wbm_dat_o;
  logic [NS-1:0]     s_cyc_o, s_stb_o, s_we_o;
  logic [NS*AW-1:0]  s_adr_o;
  logic [NS*DW-1:0]  s_dat_o;
  logic [NS*DW/8-1:0] s_sel_o;
  logic [NS-1:0]     s_ack = '0, s_err = '0, s_stall = '0;
  logic [NS*DW-1:0]  s_rdat = '0;

  int n_checks = 0;
  int n_err    = 0;

  wb_periph_mux #(
    .NS(NS), .AW(AW), .DW(DW),
    .SLAVE_ADDR(P_ADDR), .SLAVE_MASK(P_MASK), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbm_cyc_i(m_cyc), .wbm_stb_i(m_stb), .wbm_we_i(m_we),
    .wbm_adr_i(m_adr), .wbm_dat_i(m_wdat), .wbm_sel_i(m_sel),
    .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o), .wbm_stall_o(wbm_stall_o),
    .wbm_dat_o(wbm_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_ack_i(s_ack), .s_err_i(s_err), .s_stall_i(s_stall), .s_dat_i(s_rdat),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference decode: first window in table order that contains the address.
  function automatic int model_decode(input logic [31:0] a);
    for (int i = 0; i < NS; i++) begin
      if ((a & MASKS[i]) == BASES[i]) return i;
    end
    return -1;
  endfunction

  // One master transaction with a scripted slave. lat=0 means the slave never
  // responds; abort_c>0 drops wbm_cyc_i in that cycle after acceptance.
  task automatic txn(input string tag, input logic [31:0] adr, input logic we,
                     input logic [31:0] wdat, input logic [3:0] sel,
                     input int stall_n, input int lat, input bit rerr,
                     input logic [31:0] rdat, input int abort_c);
    int idx, exp_rc, exp_cyc, limit, stb_cnt, cyc_cnt, acc_c;
    int ack_cnt, err_cnt, rc, stall_gap, bad_other, bad_bus;
    bit exp_ack, exp_err, exp_busy;
    logic [NS-1:0] own;
    idx = model_decode(adr);
    own = (idx >= 0) ? (6'd1 << idx) : 6'd0;
    exp_ack = 1'b0; exp_err = 1'b0; exp_busy = 1'b0; exp_rc = 0; exp_cyc = 0;
    if (idx < 0) begin
      exp_err = 1'b1; exp_rc = 2;
    end else if (abort_c > 0) begin
      exp_cyc = abort_c;
    end else if (lat > 0) begin
      exp_rc = stall_n + lat + 2; exp_cyc = stall_n + lat + 1;
      exp_err = rerr; exp_ack = !rerr;
    end else begin
`ifdef WB_PERIPH_MUX_TIMEOUT_EN
      exp_err = 1'b1; exp_rc = TMO + 1; exp_cyc = TMO;
`else
      exp_cyc = 30; exp_busy = 1'b1;
`endif
    end
    if (exp_rc > 0) limit = exp_rc + 2;
    else if (abort_c > 0) limit = abort_c + 6;
    else limit = 30;
    stb_cnt = 0; cyc_cnt = 0; acc_c = 0; ack_cnt = 0; err_cnt = 0; rc = 0;
    stall_gap = 0; bad_other = 0; bad_bus = 0;
    for (int k = 0; k < NS; k++) s_rdat[k*DW +: DW] = $urandom;
    if (idx >= 0) s_rdat[idx*DW +: DW] = rdat;

    @(negedge clk);
    chk({tag, "_idle_stall"}, 64'(wbm_stall_o), 64'd0);
    m_cyc = 1'b1; m_stb = 1'b1; m_adr = adr; m_we = we; m_wdat = wdat; m_sel = sel;
    s_ack = '0; s_err = '0; s_stall = '0;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      if (wbm_ack_o) begin ack_cnt++; rc = c; end
      if (wbm_err_o) begin err_cnt++; rc = c; end
      if (((s_cyc_o | s_stb_o) & ~own) != '0) bad_other++;
      if (exp_rc > 0 && c <= exp_rc && !wbm_stall_o) stall_gap++;
      if (idx >= 0) begin
        if (s_cyc_o[idx]) begin
          cyc_cnt++;
          if (s_adr_o[idx*AW +: AW] !== adr || s_dat_o[idx*DW +: DW] !== wdat ||
              s_sel_o[idx*4 +: 4] !== sel || s_we_o[idx] !== we) bad_bus++;
        end
        if (s_stb_o[idx]) stb_cnt++;
      end
      m_stb = 1'b0;
      if (rc > 0 || c == abort_c) m_cyc = 1'b0;
      s_ack = NS'($urandom) & ~own;
      s_err = NS'($urandom) & ~own;
      s_stall = NS'($urandom) & ~own;
      if (idx >= 0) begin
        if (s_stb_o[idx]) begin
          if (stb_cnt <= stall_n) s_stall[idx] = 1'b1;
          else acc_c = c;
        end
        if (lat > 0 && acc_c > 0 && c == acc_c + lat) begin
          s_err[idx] = rerr;
          s_ack[idx] = rerr ? 1'($urandom_range(0, 1)) : 1'b1;
        end
      end
    end
    chk({tag, "_ack_cnt"}, 64'(ack_cnt), 64'(exp_ack));
    chk({tag, "_err_cnt"}, 64'(err_cnt), 64'(exp_err));
    if (exp_rc > 0) chk({tag, "_latency"}, 64'(rc), 64'(exp_rc));
    if (exp_ack || (exp_err && idx >= 0 && lat > 0)) chk({tag, "_rdata"}, 64'(wbm_dat_o), 64'(rdat));
    if (idx < 0) chk({tag, "_decerr_data"}, 64'(wbm_dat_o), 64'd0);
    chk({tag, "_cyc_cycles"}, 64'(cyc_cnt), 64'(exp_cyc));
    if (idx >= 0 && abort_c == 0 && lat > 0) chk({tag, "_stb_cycles"}, 64'(stb_cnt), 64'(stall_n + 1));
    chk({tag, "_other_ports"}, 64'(bad_other), 64'd0);
    chk({tag, "_bus_stable"}, 64'(bad_bus), 64'd0);
    if (exp_rc > 0) chk({tag, "_stall_held"}, 64'(stall_gap), 64'd0);
    chk({tag, "_busy_end"}, 64'(busy_o), 64'(exp_busy));
    m_cyc = 1'b0; m_stb = 1'b0;
    s_ack = '0; s_err = '0; s_stall = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic [31:0] a, d;
    #1 rst = 1'b1;
    #2;
    chk("rst_cyc", 64'(s_cyc_o), 64'd0);
    chk("rst_stb", 64'(s_stb_o), 64'd0);
    chk("rst_ack_err", 64'({wbm_ack_o, wbm_err_o}), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_dat", 64'(wbm_dat_o), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_stall", 64'(wbm_stall_o), 64'd0);

    // Mapped read to slave 2, one-cycle slave latency.
    txn("read_s2", 32'h0200_0004, 1'b0, 32'h0, 4'hF, 0, 1, 1'b0, 32'hA5A5_0001, 0);

    // Reset while the transaction sits in WAIT.
    @(negedge clk);
    m_cyc = 1'b1; m_stb = 1'b1; m_adr = 32'h0100_0020; m_we = 1'b0; m_sel = 4'hF;
    @(negedge clk);
    m_stb = 1'b0;
    @(negedge clk);
    chk("rst_mid_pre_cyc", 64'(s_cyc_o), 64'h2);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_cyc", 64'(s_cyc_o), 64'd0);
    chk("rst_mid_stb", 64'(s_stb_o), 64'd0);
    chk("rst_mid_ack_err", 64'({wbm_ack_o, wbm_err_o}), 64'd0);
    chk("rst_mid_busy", 64'(busy_o), 64'd0);
    chk("rst_mid_stall", 64'(wbm_stall_o), 64'd0);
    chk("rst_mid_dat", 64'(wbm_dat_o), 64'd0);
    m_cyc = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mid_no_resp", 64'({wbm_ack_o, wbm_err_o, busy_o}), 64'd0);

    txn("unmapped_wr", 32'h0700_0000, 1'b1, 32'h1234_5678, 4'hF, 0, 1, 1'b0, 32'h0, 0);
    txn("stall_s1", 32'h0100_0100, 1'b0, 32'h0, 4'h3, 4, 1, 1'b0, 32'h0BAD_CAFE, 0);
    txn("err_prio_s4", 32'h0400_0008, 1'b1, 32'hDEAD_BEEF, 4'h1, 1, 2, 1'b1, 32'h5555_AAAA, 0);
    txn("abort_s5", 32'h0500_0000, 1'b0, 32'h0, 4'hF, 0, 0, 1'b0, 32'h0, 2);
    txn("after_abort", 32'h0500_0010, 1'b1, 32'h0F0F_0F0F, 4'hC, 0, 2, 1'b0, 32'h7777_0000, 0);
    txn("overlap_s0", 32'h0300_0010, 1'b0, 32'h0, 4'hF, 0, 1, 1'b0, 32'h0000_0ACE, 0);
    txn("only_s3", 32'h0310_0000, 1'b0, 32'h0, 4'hF, 1, 1, 1'b0, 32'h0000_0333, 0);

    for (int n = 0; n < 24; n++) begin
      a = {8'($urandom_range(0, 8)), 24'($urandom)};
      d = $urandom;
      txn("rand", a, 1'($urandom), $urandom, 4'($urandom), $urandom_range(0, 3),
          $urandom_range(1, 3), ($urandom_range(0, 3) == 0), d, 0);
    end

    // Slave never answers: watchdog error, or an indefinite wait without it.
    txn("no_answer", 32'h0200_0040, 1'b0, 32'h0, 4'hF, 0, 0, 1'b0, 32'h0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("final_idle", 64'({busy_o, wbm_stall_o}), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
